ppu_pipe_regs: RTL
==================

// Module: ppu_pipe_regs
// PURPOSE
// - Parametrised front-end and control pipeline for the PPU: PC/nPC sequencer with delay-slot target load, IF/ID instruction register.
// - Also carries the control bundle ID->EX->MEM->WB, with stall, bubble injection and per-stage field masking.
// - Sits between instruction memory/PPU_Control_Unit and the datapath stage logic.
// - Replaces the hand-wired per-stage control bit picks.
// PARAMETERS
// - DATA_W    32       PC/nPC/instruction width
// - CTRL_W    15       control bundle width (ppu_pkg field map)
// - PC_RST    0        pc reset value
// - NPC_RST   4        npc reset value
// - PC_STEP   4        sequential nPC increment
// - EX_MASK   all-1    bundle bits kept in ID/EX
// - MEM_MASK  all-1    bits kept in EX/MEM; must be subset of EX_MASK
// - WB_MASK   all-1    bits kept in MEM/WB; must be subset of MEM_MASK
// PORTS
// - clk        in   1       clock, all regs on posedge
// - reset      in   1       asynchronous, active-high; clears all state
// - if_instr   in   DATA_W  instruction read at address pc
// - id_ctrl    in   CTRL_W  control bundle decoded from id_instr
// - id_s       in   1       control mux select; 0 -> NOP bundle into EX
// - stall      in   1       load-use hazard: freeze pc/npc/ID, bubble into EX
// - ta_valid   in   1       branch/jump taken, resolved in ID
// - ta_addr    in   DATA_W  target address
// - pc         out  DATA_W  current fetch address
// - npc        out  DATA_W  next fetch address
// - id_instr   out  DATA_W  IF/ID instruction
// - id_valid   out  1       id_instr is a real fetched instruction
// - ex_ctrl    out  CTRL_W  ID/EX bundle;  ex_valid  out 1
// - mem_ctrl   out  CTRL_W  EX/MEM bundle; mem_valid out 1
// - wb_ctrl    out  CTRL_W  MEM/WB bundle; wb_valid  out 1
// BEHAVIOUR
// - Reset (async, any time incl. mid-run):
//   - pc=PC_RST, npc=NPC_RST, id_instr=0.
//   - All *_ctrl=0, all *_valid=0.
//   - Outputs change immediately on reset assertion, not at the next clock edge.
// - Fetch, each posedge with stall=0:
//   - pc<=npc.
//   - npc<=ta_valid ? ta_addr : npc+PC_STEP, mod 2^DATA_W; wrap is silent.
//   - One delay slot: the instruction after a taken branch always executes.
// - stall=1: pc, npc, id_instr, id_valid hold; ta_valid ignored.
//   - ID must re-present ta_valid next cycle; stall has priority when both are asserted.
// - IF/ID: if stall=0 then id_instr<=if_instr, id_valid<=1.
// - ID/EX:
//   - load=id_s & ~stall & id_valid.
//   - ex_ctrl<=load ? (id_ctrl & EX_MASK) : '0.
//   - ex_valid<=load.
//   - A bubble is the all-zero NOP bundle: no RF, MEM or HI/LO write.
// - EX/MEM and MEM/WB advance every cycle (never stalled):
//   - mem_ctrl<=ex_ctrl & MEM_MASK, wb_ctrl<=mem_ctrl & WB_MASK.
//   - valid bits shift along with the bundle.
// - Latency: bundle sampled in ID at edge N appears on ex_ctrl after N, mem_ctrl after N+1, wb_ctrl after N+2.
// - Stall and bubble are independent of downstream stages; in-flight MEM/WB bundles complete during a stall.
// - No combinational path from any input to any output.
// STRUCTURE
// - ppu_pkg:
//   - CTRL_W.
//   - Field localparams: SHIFT_IMM, ALU_OP[2:0], LOAD, RF_EN, B_INSTR, TA_INSTR, MEM_SIZE[1:0], MEM_RW, MEM_SE, HI_EN, LO_EN, MEM_EN.
//   - CTRL_NOP='0.
//   - Default stage masks: EX all, MEM = MEM_*|LOAD|RF_EN|HI/LO, WB = RF_EN|HI_EN|LO_EN|LOAD.
// - Sub-module ppu_stage_reg #(W,MASK):
//   - Ports: clk, reset, en, clr, d, q, valid.
//   - Instantiated for ID/EX, EX/MEM and MEM/WB.
//   - PC/nPC logic and IF/ID stay in the top module.
// TESTING
// - Reset:
//   - Stimulus: assert reset mid-run between clock edges.
//   - Response: pc=0, npc=4, all ctrl/valid=0 immediately, before any edge.
// - Sequential:
//   - Stimulus: 5 edges, no stall/ta.
//   - Response: pc 4,8,12,16,20; npc 8,...,24; id_valid=1 after edge 1.
// - Branch:
//   - Stimulus: ta_valid=1, ta_addr=0x100 at pc=8.
//   - Response: next pc=12 (delay slot), then pc=0x100, npc=0x104.
// - Stall:
//   - Stimulus: stall=1 for 2 cycles with ADDIU bundle in ID.
//   - Response: pc/npc/id_instr hold; ex_ctrl=0 twice.
//   - Response: a prior bundle still reaches wb_ctrl; ADDIU reaches EX after stall drops.
// - Stall vs branch:
//   - Stimulus: stall=1 and ta_valid=1 in the same cycle.
//   - Response: npc unchanged; target taken on the following non-stall cycle.
// - Masking/select:
//   - Stimulus: id_s=0 -> Response: ex_ctrl=0.
//   - Stimulus: id_s=1, bundle 0x7FFF with default masks.
//   - Response: wb_ctrl has only RF_EN/HI/LO/LOAD bits set, 3 edges later.
// - Wrap:
//   - Stimulus: npc=0xFFFFFFFC, no stall.
//   - Response: npc becomes 0 with no error flag.

Source files
------------

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - PPU control bundle field map, NOP bundle and default stage masks
package ppu_pkg;

    localparam int CTRL_W = 15;

    localparam int SHIFT_IMM   = 14;
    localparam int ALU_OP_HI   = 13;
    localparam int ALU_OP_LO   = 11;
    localparam int LOAD        = 10;
    localparam int RF_EN       = 9;
    localparam int B_INSTR     = 8;
    localparam int TA_INSTR    = 7;
    localparam int MEM_SIZE_HI = 6;
    localparam int MEM_SIZE_LO = 5;
    localparam int MEM_RW      = 4;
    localparam int MEM_SE      = 3;
    localparam int HI_EN       = 2;
    localparam int LO_EN       = 1;
    localparam int MEM_EN      = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t field_bit(int pos);
        return ctrl_t'(1) << pos;
    endfunction

    localparam ctrl_t EX_MASK_DEF  = '1;
    // MEM keeps the memory-access fields plus everything WB still needs
    localparam ctrl_t MEM_MASK_DEF = field_bit(MEM_EN) | field_bit(MEM_RW) | field_bit(MEM_SE)
                                   | field_bit(MEM_SIZE_HI) | field_bit(MEM_SIZE_LO)
                                   | field_bit(LOAD) | field_bit(RF_EN)
                                   | field_bit(HI_EN) | field_bit(LO_EN);
    localparam ctrl_t WB_MASK_DEF  = field_bit(RF_EN) | field_bit(HI_EN)
                                   | field_bit(LO_EN) | field_bit(LOAD);

endpackage

// File: rtl/ppu_pipe_regs_if.sv
// rtl/ppu_pipe_regs_if.sv - fetch/decode inputs and pipeline register outputs of ppu_pipe_regs
interface ppu_pipe_regs_if
    import ppu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int C_W    = CTRL_W
);
    logic [DATA_W-1:0] if_instr;
    logic [C_W-1:0]    id_ctrl;
    logic              id_s;
    logic              stall;
    logic              ta_valid;
    logic [DATA_W-1:0] ta_addr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] id_instr;
    logic              id_valid;
    logic [C_W-1:0]    ex_ctrl;
    logic              ex_valid;
    logic [C_W-1:0]    mem_ctrl;
    logic              mem_valid;
    logic [C_W-1:0]    wb_ctrl;
    logic              wb_valid;

    modport master (
        output if_instr, id_ctrl, id_s, stall, ta_valid, ta_addr,
        input  pc, npc, id_instr, id_valid, ex_ctrl, ex_valid,
               mem_ctrl, mem_valid, wb_ctrl, wb_valid
    );

    modport slave (
        input  if_instr, id_ctrl, id_s, stall, ta_valid, ta_addr,
        output pc, npc, id_instr, id_valid, ex_ctrl, ex_valid,
               mem_ctrl, mem_valid, wb_ctrl, wb_valid
    );
endinterface

// File: rtl/ppu_stage_reg.sv
// rtl/ppu_stage_reg.sv - one control pipeline stage: masked bundle register with valid bit
module ppu_stage_reg #(
    parameter int           W    = 15,
    parameter logic [W-1:0] MASK = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // clr loads the all-zero NOP bundle, so a bubble can never write anything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (en) begin
            if (clr) begin
                q     <= '0;
                valid <= 1'b0;
            end else begin
                q     <= d & MASK;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppu_pipe_regs.sv
// rtl/ppu_pipe_regs.sv - PPU PC/nPC sequencer, IF/ID register and ID->EX->MEM->WB control pipeline
module ppu_pipe_regs
    import ppu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                C_W      = CTRL_W,
    parameter logic [DATA_W-1:0] PC_RST   = '0,
    parameter logic [DATA_W-1:0] NPC_RST  = DATA_W'(4),
    parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4),
    parameter logic [C_W-1:0]    EX_MASK  = EX_MASK_DEF,
    parameter logic [C_W-1:0]    MEM_MASK = MEM_MASK_DEF,
    parameter logic [C_W-1:0]    WB_MASK  = WB_MASK_DEF
) (
    input logic             clk,
    input logic             reset,
    ppu_pipe_regs_if.slave  bus
);

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] npc_q;
    logic [DATA_W-1:0] id_instr_q;
    logic              id_valid_q;
    logic              ex_load;
    logic [C_W-1:0]    ex_ctrl_q;
    logic [C_W-1:0]    mem_ctrl_q;
    logic [C_W-1:0]    wb_ctrl_q;
    logic              ex_valid_q;
    logic              mem_valid_q;
    logic              wb_valid_q;

    // stall freezes the front end entirely; a branch seen during stall is re-presented by ID
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= PC_RST;
            npc_q      <= NPC_RST;
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q       <= npc_q;
            npc_q      <= bus.ta_valid ? bus.ta_addr : npc_q + PC_STEP;
            id_instr_q <= bus.if_instr;
            id_valid_q <= 1'b1;
        end
    end

    assign ex_load = bus.id_s & ~bus.stall & id_valid_q;

    ppu_stage_reg #(.W(C_W), .MASK(EX_MASK)) u_id_ex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (~ex_load),
        .d     (bus.id_ctrl),
        .q     (ex_ctrl_q),
        .valid (ex_valid_q)
    );

    // downstream stages never stall so in-flight bundles drain during a hazard
    ppu_stage_reg #(.W(C_W), .MASK(MEM_MASK)) u_ex_mem (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (~ex_valid_q),
        .d     (ex_ctrl_q),
        .q     (mem_ctrl_q),
        .valid (mem_valid_q)
    );

    ppu_stage_reg #(.W(C_W), .MASK(WB_MASK)) u_mem_wb (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (~mem_valid_q),
        .d     (mem_ctrl_q),
        .q     (wb_ctrl_q),
        .valid (wb_valid_q)
    );

    assign bus.pc        = pc_q;
    assign bus.npc       = npc_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.mem_ctrl  = mem_ctrl_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.wb_ctrl   = wb_ctrl_q;
    assign bus.wb_valid  = wb_valid_q;

endmodule
